systolic_pe_acc: RTL

Parametrised second-generation processing element for the systolic matrix-multiply array. It forwards A/B operands and their beat qualifiers one hop per cycle. It multiplies through a two-stage pipeline with a wide accumulator, optional signed arithmetic and saturation. Finished dot products are held in a result register and unloaded through a per-PE drain shift chain. It drops into the same mesh positions as the existing PE and adds valid-qualified bubbles, first/last framing, overflow tracking and result-overrun detection.

---
 rtl/systolic_pkg.sv | 41 ++++
 rtl/pe_mac_stage.sv | 77 +++++++
 rtl/systolic_pe_acc.sv | 102 ++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared width-generic arithmetic helpers for the systolic PE
package systolic_pkg;

  localparam int unsigned MAX_W = 64;
  typedef logic [MAX_W-1:0] word_t;

  function automatic word_t umax_of(input int unsigned w);
    return (w >= MAX_W) ? '1 : ((word_t'(1) << w) - word_t'(1));
  endfunction

  function automatic word_t smax_of(input int unsigned w);
    return umax_of(w) >> 1;
  endfunction

  function automatic word_t smin_of(input int unsigned w);
    return word_t'(1) << (w - 1);
  endfunction

  // Adds two w-bit values held in the low bits of a word; returns {ovf, sum}.
  function automatic logic [MAX_W:0] sat_add(input logic signed_mode, input logic sat_en,
                                             input int unsigned w, input word_t a, input word_t b);
    logic [MAX_W:0] wide;
    word_t          sum;
    logic           ovf;
    logic [5:0]     msb;
    logic [6:0]     cidx;
    msb  = 6'(w - 1);
    cidx = 7'(w);
    wide = {1'b0, a} + {1'b0, b};
    sum  = wide[MAX_W-1:0] & umax_of(w);
    if (signed_mode) ovf = (a[msb] == b[msb]) && (sum[msb] != a[msb]);
    else             ovf = wide[cidx];
    if (ovf && sat_en) begin
      if (!signed_mode) sum = umax_of(w);
      else if (a[msb])  sum = smin_of(w);
      else              sum = smax_of(w);
    end
    return {ovf, sum};
  endfunction

endpackage

// File: rtl/pe_mac_stage.sv
// rtl/pe_mac_stage.sv - two-stage multiply/accumulate with overflow tracking and saturation
module pe_mac_stage
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              signed_mode,
  input  logic              sat_en,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              valid_in,
  input  logic              first_in,
  input  logic              last_in,
  output logic              cap_valid,
  output logic [ACC_W-1:0]  acc_next,
  output logic              acc_ovf_next
);

  localparam int PW = 2 * DATA_W;

  if (ACC_W < PW || ACC_W > MAX_W) begin : g_bad_width
    $error("pe_mac_stage: ACC_W must lie between 2*DATA_W and 64");
  end

  logic [PW-1:0]        r_prod;
  logic                 r_v1, r_f1, r_l1;
  logic [ACC_W-1:0]     r_acc;
  logic                 r_acc_ovf;
  logic signed [PW-1:0] w_prod_s;
  logic [PW-1:0]        w_prod_u;
  logic [ACC_W-1:0]     w_ext, w_base;
  logic [MAX_W:0]       w_sum;

  assign w_prod_s = PW'($signed(a_in)) * PW'($signed(b_in));
  assign w_prod_u = PW'(a_in) * PW'(b_in);

  always_comb begin
    w_ext = ACC_W'(r_prod);
    if (signed_mode) w_ext = ACC_W'($signed(r_prod));
  end

  // A first beat restarts from zero, so its own add can never overflow.
  assign w_base       = r_f1 ? '0 : r_acc;
  assign w_sum        = sat_add(signed_mode, sat_en, ACC_W, word_t'(w_base), word_t'(w_ext));
  assign acc_next     = w_sum[ACC_W-1:0];
  assign acc_ovf_next = w_sum[MAX_W] | (~r_f1 & r_acc_ovf);
  assign cap_valid    = r_v1 & r_l1;

  if (ACC_W < MAX_W) begin : g_pad
    logic w_unused;
    assign w_unused = ^w_sum[MAX_W-1:ACC_W];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prod    <= '0;
      r_v1      <= 1'b0;
      r_f1      <= 1'b0;
      r_l1      <= 1'b0;
      r_acc     <= '0;
      r_acc_ovf <= 1'b0;
    end else begin
      r_prod <= signed_mode ? w_prod_s : w_prod_u;
      r_v1   <= valid_in;
      r_f1   <= first_in;
      r_l1   <= last_in;
      if (r_v1) begin
        r_acc     <= acc_next;
        r_acc_ovf <= acc_ovf_next;
      end
    end
  end

endmodule

// File: rtl/systolic_pe_acc.sv
// rtl/systolic_pe_acc.sv - systolic PE: operand forwarding, MAC, result register and drain chain
module systolic_pe_acc
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              signed_mode,
  input  logic              sat_en,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              valid_in,
  input  logic              first_in,
  input  logic              last_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              valid_out,
  output logic              first_out,
  output logic              last_out,
  input  logic              drain_load,
  input  logic              drain_shift,
  input  logic [ACC_W-1:0]  drain_in,
  input  logic              drain_ovf_in,
  output logic [ACC_W-1:0]  drain_out,
  output logic              drain_ovf_out,
  output logic              res_valid,
  output logic              overrun
);

  logic [DATA_W-1:0] r_a, r_b;
  logic              r_v, r_f, r_l;
  logic [ACC_W-1:0]  r_res, r_drain;
  logic              r_res_ovf, r_res_valid, r_drain_ovf, r_overrun;
  logic              w_cap;
  logic [ACC_W-1:0]  w_acc_next;
  logic              w_acc_ovf_next;

  pe_mac_stage #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk          (clk),
    .reset_n      (reset_n),
    .signed_mode  (signed_mode),
    .sat_en       (sat_en),
    .a_in         (a_in),
    .b_in         (b_in),
    .valid_in     (valid_in),
    .first_in     (first_in),
    .last_in      (last_in),
    .cap_valid    (w_cap),
    .acc_next     (w_acc_next),
    .acc_ovf_next (w_acc_ovf_next)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_v         <= 1'b0;
      r_f         <= 1'b0;
      r_l         <= 1'b0;
      r_res       <= '0;
      r_res_ovf   <= 1'b0;
      r_res_valid <= 1'b0;
      r_drain     <= '0;
      r_drain_ovf <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_a <= a_in;
      r_b <= b_in;
      r_v <= valid_in;
      r_f <= first_in;
      r_l <= last_in;
      if (w_cap) begin
        r_res     <= w_acc_next;
        r_res_ovf <= w_acc_ovf_next;
      end
      // A capture landing on the unload cycle keeps the new result pending.
      if (w_cap)           r_res_valid <= 1'b1;
      else if (drain_load) r_res_valid <= 1'b0;
      if (w_cap && r_res_valid && !drain_load) r_overrun <= 1'b1;
      if (drain_load) begin
        r_drain     <= r_res;
        r_drain_ovf <= r_res_ovf;
      end else if (drain_shift) begin
        r_drain     <= drain_in;
        r_drain_ovf <= drain_ovf_in;
      end
    end
  end

  assign a_out         = r_a;
  assign b_out         = r_b;
  assign valid_out     = r_v;
  assign first_out     = r_f;
  assign last_out      = r_l;
  assign drain_out     = r_drain;
  assign drain_ovf_out = r_drain_ovf;
  assign res_valid     = r_res_valid;
  assign overrun       = r_overrun;

endmodule
